// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM definitions for the ALU scheduler slice.
package alu_pkg;

    localparam int unsigned ALU_W = 8;
    localparam int unsigned OUT_W = 16;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_XOR     = 3'd2;
    localparam logic [2:0] OP_ADD     = 3'd3;
    localparam logic [2:0] OP_SUB     = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_DIV     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-side request/response bus of the ALU scheduler.
interface alu_scheduler_if #(
    parameter int unsigned N_REQ = 2
);
    import alu_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op;
    logic [ALU_W*N_REQ-1:0] req_x;
    logic [ALU_W*N_REQ-1:0] req_y;
    logic [ALU_W*N_REQ-1:0] req_a_div;
    logic [N_REQ-1:0]       rsp_valid;
    logic [OUT_W-1:0]       rsp_data;
    logic                   rsp_err;

    modport master (
        output req_valid, req_op, req_x, req_y, req_a_div,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_a_div,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request strictly after ptr wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!valid && req[i] && (i == (32'(ptr) + k) % N_REQ)) begin
                    valid    = 1'b1;
                    idx      = IDX_W'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one multi-cycle ALU between N_REQ requesters, one operation at a time,
// with round-robin acceptance, END edge detection and a completion timeout.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic             clk,
    input  logic             resetn,
    alu_scheduler_if.slave   req_bus,
    output logic             busy,
    output logic [ALU_W-1:0] alu_x,
    output logic [ALU_W-1:0] alu_y,
    output logic [ALU_W-1:0] alu_a_div,
    output logic [2:0]       alu_op,
    output logic             alu_begin,
    input  logic [OUT_W-1:0] alu_out,
    input  logic             alu_end
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
    logic [N_REQ-1:0] gnt, owner_oh;
    logic [N_REQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic             gnt_valid, done, expired;
    logic [2:0]       gnt_op, alu_op_q, alu_op_d;
    logic [ALU_W-1:0] gnt_x, gnt_y, gnt_a;
    logic [ALU_W-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d, alu_a_q, alu_a_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d, alu_begin_q, alu_begin_d;
    logic             busy_q, busy_d, end_q, end_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    always_comb begin
        gnt_op   = '0;
        gnt_x    = '0;
        gnt_y    = '0;
        gnt_a    = '0;
        owner_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_op = req_bus.req_op[3*i +: 3];
                gnt_x  = req_bus.req_x[ALU_W*i +: ALU_W];
                gnt_y  = req_bus.req_y[ALU_W*i +: ALU_W];
                gnt_a  = req_bus.req_a_div[ALU_W*i +: ALU_W];
            end
            owner_oh[i] = (32'(owner_q) == i);
        end
    end

    // A stale high END left over from the previous operation is not a completion.
    assign done    = (state_q == S_WAIT) && alu_end && !end_q;
    assign expired = (state_q == S_WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_valid) state_d = (gnt_op == OP_ILLEGAL) ? S_RESP : S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (done || expired) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        alu_op_d    = alu_op_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_a_d     = alu_a_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        alu_begin_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        end_d       = end_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    req_ready_d = gnt;
                    rr_ptr_d    = gnt_idx;
                    owner_d     = gnt_idx;
                    alu_op_d    = gnt_op;
                    alu_x_d     = gnt_x;
                    alu_y_d     = gnt_y;
                    alu_a_d     = gnt_a;
                    if (gnt_op == OP_ILLEGAL) begin
                        rsp_valid_d = gnt;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        alu_begin_d = 1'b1;
                    end
                end
            end
            S_START: begin
                cnt_d = '0;
                end_d = alu_end;
            end
            S_WAIT: begin
                end_d = alu_end;
                if (done) begin
                    rsp_valid_d = owner_oh;
                    rsp_data_d  = alu_out;
                    rsp_err_d   = 1'b0;
                end else if (expired) begin
                    rsp_valid_d = owner_oh;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            alu_op_q    <= OP_AND;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_a_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            alu_begin_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            end_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            alu_op_q    <= alu_op_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_a_q     <= alu_a_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            alu_begin_q <= alu_begin_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
        end
    end

    assign req_bus.req_ready = req_ready_q;
    assign req_bus.rsp_valid = rsp_valid_q;
    assign req_bus.rsp_data  = rsp_data_q;
    assign req_bus.rsp_err   = rsp_err_q;
    assign busy              = busy_q;
    assign alu_x             = alu_x_q;
    assign alu_y             = alu_y_q;
    assign alu_a_div         = alu_a_q;
    assign alu_op            = alu_op_q;
    assign alu_begin         = alu_begin_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with a behavioural multi-cycle ALU stub.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 7;

    typedef struct {
        int          req;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        busy, alu_begin;
    logic [7:0]  alu_x, alu_y, alu_a_div;
    logic [2:0]  alu_op;
    logic [15:0] alu_out = '0;
    logic        alu_end = 1'b0;

    always #5 clk = ~clk;

    alu_scheduler_if #(.N_REQ(N_REQ)) bus ();

    alu_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_bus   (bus),
        .busy      (busy),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_a_div (alu_a_div),
        .alu_op    (alu_op),
        .alu_begin (alu_begin),
        .alu_out   (alu_out),
        .alu_end   (alu_end)
    );

    int   vectors = 0, miscompares = 0;
    exp_t exp_q[$];
    int   grant_log[$];
    int   begin_cnt = 0, legal_acc = 0, rsp_cnt = 0, cyc = 0;
    int   last_begin_cyc = 0, last_rsp_cyc = 0;
    logic [N_REQ-1:0] valid_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU semantics: DIV is {a_div,x}/y -> {remainder, quotient}.
    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] x,
                                            input logic [7:0] y, input logic [7:0] a);
        int          sx, sy;
        int unsigned ux, uy, dvd;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = x;
        uy  = y;
        dvd = {a, x};
        case (op)
            3'd0: return {8'h00, x & y};
            3'd1: return {8'h00, x | y};
            3'd2: return {8'h00, x ^ y};
            3'd3: return 16'(ux + uy);
            3'd4: return 16'(sx - sy);
            3'd5: return 16'(sx * sy);
            3'd6: begin
                if (uy == 0) return 16'hFFFF;
                return {8'(dvd % uy), 8'(dvd / uy)};
            end
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stub: END stays stale-high one WAIT cycle, drops, then rises after lat cycles.
    logic       hang = 1'b0, active = 1'b0, unstable = 1'b0;
    int         k = 0, lat = 1;
    logic [7:0] cx, cy, ca;
    logic [2:0] cop;

    always @(negedge clk) begin
        if (!resetn) begin
            alu_end = 1'b0;
            active  = 1'b0;
        end else if (alu_begin) begin
            cx = alu_x; cy = alu_y; ca = alu_a_div; cop = alu_op;
            k = 0; active = 1'b1; unstable = 1'b0;
            lat = $urandom_range(5, 1);
            alu_out = 16'($urandom);
        end else if (active) begin
            k++;
            if (alu_x !== cx || alu_y !== cy || alu_a_div !== ca || alu_op !== cop) unstable = 1'b1;
            if (k == 2) alu_end = 1'b0;
            if (!hang && k == 2 + lat) begin
                alu_end = 1'b1;
                alu_out = alu_ref(cop, cx, cy, ca);
                active  = 1'b0;
            end
        end
    end

    always @(posedge clk) valid_prev = bus.req_valid;

    // Monitor: grants must follow a valid request; responses pop the scoreboard.
    always @(negedge clk) begin
        int owner, hit;
        if (resetn) begin
            if (alu_begin) begin
                begin_cnt++;
                last_begin_cyc = cyc;
            end
            if (bus.req_ready != '0) begin
                check("ready_onehot", $countones(bus.req_ready), 1);
                for (int r = 0; r < N_REQ; r++) begin
                    if (bus.req_ready[r]) begin
                        check("ready_had_valid", valid_prev[r], 1);
                        grant_log.push_back(r);
                    end
                end
            end
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                check("rsp_onehot", $countones(bus.rsp_valid), 1);
                owner = 0;
                for (int r = N_REQ - 1; r >= 0; r--) if (bus.rsp_valid[r]) owner = r;
                hit = -1;
                foreach (exp_q[i]) if (hit < 0 && exp_q[i].req == owner) hit = i;
                if (hit < 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_data", bus.rsp_data, exp_q[hit].data);
                    check("rsp_err", bus.rsp_err, exp_q[hit].err);
                    if (!exp_q[hit].err) check("operand_stable", unstable, 0);
                    exp_q.delete(hit);
                end
            end
        end
        cyc++;
    end

    task automatic issue(input int r, input logic [2:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] a,
                         input logic [15:0] ed, input logic ee);
        int   c;
        logic acc;
        exp_t e;
        e.req = r; e.data = ed; e.err = ee;
        exp_q.push_back(e);
        bus.req_op[r*3 +: 3]    = op;
        bus.req_x[r*8 +: 8]     = x;
        bus.req_y[r*8 +: 8]     = y;
        bus.req_a_div[r*8 +: 8] = a;
        bus.req_valid[r]        = 1'b1;
        c = 0;
        acc = 1'b0;
        while (!acc && c < 400) begin
            @(negedge clk);
            c++;
            if (bus.req_ready[r]) acc = 1'b1;
        end
        bus.req_valid[r] = 1'b0;
        if (!acc) check("accept_timeout", 1, 0);
        else if (op != OP_ILLEGAL) legal_acc++;
    endtask

    task automatic rand_stream(input int r, input int n, input int max_gap);
        logic [2:0]  op;
        logic [7:0]  x, y, a;
        logic [15:0] ed;
        logic        ee;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(7, 0));
            x  = 8'($urandom);
            y  = 8'($urandom);
            a  = 8'($urandom);
            ee = (op == OP_ILLEGAL);
            ed = ee ? 16'h0000 : alu_ref(op, x, y, a);
            issue(r, op, x, y, a, ed, ee);
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_begin", alu_begin, 0);
        check("rst_alu_operands", {alu_x, alu_y, alu_a_div}, 0);
        check("rst_alu_op", alu_op, 0);
    endtask

    initial begin
        int b0, base, ones, snap;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_a_div = '0;
        repeat (3) @(negedge clk);
        check_reset();
        resetn = 1'b1;
        @(negedge clk);

        issue(0, OP_ADD, 8'h11, 8'h05, 8'h00, 16'h0016, 1'b0);
        drain();
        check("add_begin_pulses", begin_cnt, 1);
        check("idle_busy", busy, 0);

        issue(1, OP_DIV, 8'h8B, 8'h87, 8'h16, 16'h652A, 1'b0);
        drain();

        issue(0, OP_MUL, 8'hB9, 8'h85, 8'h00, 16'h221D, 1'b0);
        check("start_busy", busy, 1);
        drain();

        b0 = begin_cnt;
        issue(1, OP_ILLEGAL, 8'h12, 8'h34, 8'h56, 16'h0000, 1'b1);
        drain();
        check("illegal_no_begin", begin_cnt, b0);

        hang = 1'b1;
        issue(0, OP_XOR, 8'hF0, 8'h0F, 8'h00, 16'h0000, 1'b1);
        drain();
        hang = 1'b0;
        check("timeout_cycles", last_rsp_cyc - last_begin_cyc, TIMEOUT + 1);
        issue(1, OP_SUB, 8'h10, 8'h20, 8'h00, 16'hFFF0, 1'b0);
        drain();

        // Requester 1 withdraws while the ALU is busy for requester 0.
        base = grant_log.size();
        fork
            issue(0, OP_OR, 8'hA0, 8'h05, 8'h00, 16'h00A5, 1'b0);
            begin
                repeat (2) @(negedge clk);
                bus.req_valid[1] = 1'b1;
                repeat (2) @(negedge clk);
                bus.req_valid[1] = 1'b0;
            end
        join
        drain();
        repeat (3) @(negedge clk);
        ones = 0;
        for (int i = base; i < grant_log.size(); i++) if (grant_log[i] == 1) ones++;
        check("withdraw_no_grant", ones, 0);

        // Reset while stuck in WAIT aborts the operation.
        hang = 1'b1;
        issue(0, OP_ADD, 8'h01, 8'h02, 8'h00, 16'h0003, 1'b0);
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_reset();
        exp_q.delete();
        snap = rsp_cnt;
        @(negedge clk);
        @(negedge clk);
        hang = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("no_rsp_after_abort", rsp_cnt, snap);

        // Both requesters continuously valid: strict alternation starting at 0.
        base = grant_log.size();
        fork
            rand_stream(0, 4, 0);
            rand_stream(1, 4, 0);
        join
        drain();
        check("rr_grant_count", grant_log.size() - base, 8);
        for (int i = 0; i < 8 && base + i < grant_log.size(); i++)
            check("rr_order", grant_log[base+i], i % 2);

        fork
            rand_stream(0, 12, 3);
            rand_stream(1, 12, 3);
        join
        drain();
        check("begin_vs_legal", begin_cnt, legal_acc);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
